// File: rtl/adc_spi_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// adc_spi_pkg : shared FSM encoding and frame constants for the ADC scan controller.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int FRAME_BITS      = 16;
  localparam int TICKS_PER_FRAME = 32;
  localparam int ADDR_MSB_BIT    = 13;

endpackage

`default_nettype wire

// File: rtl/adc_spi_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// adc_spi_scan_ctrl_if : user-side scan request / sample stream of the ADC scan controller.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface adc_spi_scan_ctrl_if #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 12
) ();

  logic              start;
  logic              cont_mode;
  logic [NUM_CH-1:0] ch_mask;
  logic              busy;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [ADDR_W-1:0] sample_ch;
  logic              scan_done;
  logic              frame_err;

  modport master (
    output start, cont_mode, ch_mask,
    input  busy, sample_valid, sample_data, sample_ch, scan_done, frame_err
  );

  modport slave (
    input  start, cont_mode, ch_mask,
    output busy, sample_valid, sample_data, sample_ch, scan_done, frame_err
  );

endinterface

`default_nettype wire

// File: rtl/adc_spi_scan_ctrl_tick.sv
// ----------------------------------------------------------------------------
// adc_sclk_tick : free-running divider, one-clk tick per SCLK half-period.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adc_sclk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (cnt == TERM)  cnt <= '0;
    else                   cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == TERM);

endmodule

`default_nettype wire

// File: rtl/adc_spi_scan_ctrl.sv
// ----------------------------------------------------------------------------
// adc_spi_scan_ctrl : ascending-mask scan controller for ADC128S102-class SPI ADCs.  Rev 1.0
// Optional leading-bit frame checker: define ADC_SCAN_FRAME_CHK_EN.
// ----------------------------------------------------------------------------
`default_nettype none

module adc_spi_scan_ctrl
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int NUM_CH  = 8,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  adc_spi_scan_ctrl_if.slave usr,
  output logic               cs_n,
  output logic               sclk,
  output logic               din,
  input  logic               dout
);

`ifdef ADC_SCAN_FRAME_CHK_EN
  localparam int SR_W = FRAME_BITS - 1;
`else
  localparam int SR_W = DATA_W - 1;
`endif
  localparam int         WORD_W       = SR_W + 1;
  localparam int         ADDR_LSB_BIT = ADDR_MSB_BIT + 1 - ADDR_W;
  localparam logic [4:0] LAST_TICK    = 5'(TICKS_PER_FRAME - 1);

  state_t              state, state_nx;
  logic                tick, busy, flush, first_frame;
  logic                start_ok, frame_end, restart, nxt_found;
  logic [NUM_CH-1:0]   mask;
  logic [ADDR_W-1:0]   cur_addr, prev_addr, nxt_addr;
  logic [4:0]          tcnt;
  logic [SR_W-1:0]     shreg;
  logic [WORD_W-1:0]   word;
  logic [FRAME_BITS-1:0] addr_word;
  logic [3:0]          nxt_bit;
  logic                sample_valid, scan_done;
  logic [DATA_W-1:0]   sample_data;
  logic [ADDR_W-1:0]   sample_ch;

  function automatic logic [ADDR_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest = ADDR_W'(i);
  endfunction

  adc_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign start_ok  = usr.start && (state == ST_IDLE) && !busy && (|usr.ch_mask);
  assign frame_end = (state == ST_SHIFT) && tick && (tcnt == LAST_TICK);
  assign restart   = (state == ST_HOLD) && (state_nx == ST_SETUP);
  assign word      = {shreg, dout};
  assign addr_word = FRAME_BITS'(cur_addr) << ADDR_LSB_BIT;
  // Bit index of the even tick that follows odd tick tcnt.
  assign nxt_bit   = 4'd14 - tcnt[4:1];

  always_comb begin
    nxt_found = 1'b0;
    nxt_addr  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur_addr))) begin
        nxt_found = 1'b1;
        nxt_addr  = ADDR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // busy in IDLE means a start was accepted and SETUP waits for the next tick.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (busy && tick) state_nx = ST_SETUP;
      ST_SETUP: if (tick) state_nx = ST_SHIFT;
      ST_SHIFT: if (frame_end && flush) state_nx = ST_HOLD;
      ST_HOLD:  if (tick) state_nx = (usr.cont_mode && (|usr.ch_mask)) ? ST_SETUP : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      mask         <= '0;
      cur_addr     <= '0;
      prev_addr    <= '0;
      tcnt         <= '0;
      shreg        <= '0;
      flush        <= 1'b0;
      first_frame  <= 1'b0;
      cs_n         <= 1'b1;
      sclk         <= 1'b1;
      din          <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      scan_done    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      cs_n         <= !((state_nx == ST_SETUP) || (state_nx == ST_SHIFT));
      if (start_ok) begin
        busy <= 1'b1;
        mask <= usr.ch_mask;
      end
      if (restart) mask <= usr.ch_mask;
      if ((state == ST_HOLD) && (state_nx == ST_IDLE)) busy <= 1'b0;
      if ((state != ST_SETUP) && (state_nx == ST_SETUP)) begin
        cur_addr    <= lowest(restart ? usr.ch_mask : mask);
        flush       <= 1'b0;
        first_frame <= 1'b1;
      end
      if ((state == ST_SETUP) && tick) begin
        tcnt <= '0;
        sclk <= 1'b0;
        din  <= 1'b0;
      end
      if ((state == ST_SHIFT) && tick) begin
        tcnt <= tcnt + 5'd1;
        if (!tcnt[0]) begin
          sclk <= 1'b1;
        end else begin
          shreg <= word[SR_W-1:0];
          if (tcnt != LAST_TICK) begin
            sclk <= 1'b0;
            din  <= addr_word[nxt_bit];
          end else begin
            sclk <= flush;
            din  <= 1'b0;
          end
        end
      end
      if (frame_end) begin
        if (!first_frame) begin
          sample_valid <= 1'b1;
          sample_data  <= word[DATA_W-1:0];
          sample_ch    <= prev_addr;
          scan_done    <= flush;
        end
        first_frame <= 1'b0;
        if (!flush) begin
          prev_addr <= cur_addr;
          if (nxt_found) begin
            cur_addr <= nxt_addr;
          end else begin
            cur_addr <= lowest(mask);
            flush    <= 1'b1;
          end
        end
      end
    end
  end

`ifdef ADC_SCAN_FRAME_CHK_EN
  logic frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_err <= 1'b0;
    else if (start_ok)
      frame_err <= 1'b0;
    else if (frame_end && !first_frame && (|word[WORD_W-1:DATA_W]))
      frame_err <= 1'b1;
  end

  assign usr.frame_err = frame_err;
`else
  assign usr.frame_err = 1'b0;
`endif

  assign usr.busy         = busy;
  assign usr.sample_valid = sample_valid;
  assign usr.sample_data  = sample_data;
  assign usr.sample_ch    = sample_ch;
  assign usr.scan_done    = scan_done;

endmodule

`default_nettype wire
